// File: rtl/fpio_out_serializer_pkg.sv
// Shared types and helpers for the FPIO output serializer.
package fpio_out_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Width of a counter that indexes every bit of a data word.
  function automatic int unsigned bit_cnt_width(int unsigned data_width);
    return (data_width < 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/fpio_out_serializer_if.sv
// FPIO FIFO output handshake: the server presents words, the client pulls them.
interface fpio_fifo_if #(
  parameter int unsigned FIFO_BITS  = 4,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [FIFO_BITS:0]    avail;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_ack;
  logic                  data_en;

  modport fifo_out_client (
    input  avail,
    input  data,
    input  data_ack,
    output data_en
  );

  modport fifo_out_server (
    output avail,
    output data,
    output data_ack,
    input  data_en
  );

endinterface

// File: rtl/fpio_bit_timer.sv
// Bit-period down-counter: marks the first and last clock of each serial bit.
module fpio_bit_timer #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  output logic                 bit_stb,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;

  // start wins over run so a back-to-back word load restarts the period cleanly.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
      div_q <= clkdiv;
    end else if (run) begin
      cnt_q <= bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  always_comb begin
    bit_stb = run && (cnt_q == '0);
    bit_end = run && (cnt_q == div_q);
  end

endmodule

// File: rtl/fpio_out_serializer.sv
// Pulls words from an FPIO output FIFO and shifts them out on one pin,
// prefetching into a holding register so consecutive words stream gap-free.
module fpio_out_serializer
  import fpio_out_serializer_pkg::*;
#(
  parameter int unsigned FIFO_BITS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  fpio_fifo_if.fifo_out_client fifo,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  input  logic                 lsb_first,
  input  logic                 underrun_clr,
  output logic                 sdo,
  output logic                 sdo_valid,
  output logic                 bit_stb,
  output logic                 busy,
  output logic                 underrun
);

  localparam int unsigned    CntW    = bit_cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  lsb_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic                  data_en_q;
  logic                  underrun_q;

  logic [FIFO_BITS:0]    avail;
  logic                  shifting;
  logic                  load;
  logic                  word_end;
  logic                  underrun_set;
  logic                  bit_end;

  assign avail        = fifo.avail;
  assign fifo.data_en = data_en_q;
  assign shifting     = (state_q == StShift);

  fpio_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .start  (load),
    .run    (shifting),
    .clkdiv (clkdiv),
    .bit_stb(bit_stb),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    word_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_valid_q && enable) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bit_end && (bit_cnt_q == LastBit)) begin
          word_end = 1'b1;
          if (hold_valid_q && enable) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    underrun_set = word_end && enable && !hold_valid_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      lsb_q        <= 1'b0;
      bit_cnt_q    <= '0;
      data_en_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // A fetch is only issued into an empty holding register, so capture and
      // load never collide on the same edge.
      if (load) begin
        hold_valid_q <= 1'b0;
      end
      if (data_en_q) begin
        if (fifo.data_ack) begin
          data_en_q    <= 1'b0;
          hold_q       <= fifo.data;
          hold_valid_q <= 1'b1;
        end
      end else if (enable && (avail != '0) && !hold_valid_q) begin
        data_en_q <= 1'b1;
      end

      if (load) begin
        shreg_q   <= hold_q;
        lsb_q     <= lsb_first;
        bit_cnt_q <= '0;
      end else if (bit_end && (bit_cnt_q != LastBit)) begin
        bit_cnt_q <= bit_cnt_q + CntW'(1);
        shreg_q   <= lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
      end

      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

  always_comb begin
    sdo = 1'b0;
    if (shifting) begin
      sdo = lsb_q ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
    end
    sdo_valid = shifting;
    busy      = shifting || hold_valid_q || data_en_q;
    underrun  = underrun_q;
  end

endmodule
